// File: rtl/alu_exec.sv
// alu_exec: execute stage between register file read ports and its write port; start/busy/done handshake.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier; without it op 111 passes opa through.
module alu_exec #(
  parameter int W       = 8,
  parameter int MUL_CYC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [2:0]   dst,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         wr_en,
  output logic [2:0]   wr_sel,
  output logic [W-1:0] hi,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  if (MUL_CYC != W) begin : g_cfg_check
    $error("alu_exec: MUL_CYC must equal W");
  end

  state_t       state_q, state_d;
  logic [2:0]   op_q, op_d, dst_q, dst_d, wr_sel_q, wr_sel_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, hi_q, hi_d;
  logic         z_q, z_d, c_q, c_d, v_q, v_d;

  logic [W:0]   add_w, sub_w;
  logic [W-1:0] alu_r;
  logic         alu_c, alu_v;

  always_comb begin
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} - {1'b0, b_q};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_r = add_w[W-1:0];
        alu_c = add_w[W];
        alu_v = (a_q[W-1] == b_q[W-1]) && (alu_r[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_r = sub_w[W-1:0];
        alu_c = sub_w[W];
        alu_v = (a_q[W-1] != b_q[W-1]) && (alu_r[W-1] != a_q[W-1]);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_SHL: begin
        alu_r = {a_q[W-2:0], 1'b0};
        alu_c = a_q[W-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, a_q[W-1:1]};
        alu_c = a_q[0];
      end
      default: alu_r = a_q;  // op 111 when the multiplier is not built
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = $clog2(MUL_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYC - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d, mul_next;
  logic [W:0]     mul_sum;

  // Accumulator is {partial product, remaining multiplier}; the carry shifts back in from the top.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]};
    if (acc_q[0]) mul_sum = mul_sum + {1'b0, a_q};
    mul_next = {mul_sum, acc_q[W-1:1]};
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    wr_sel_d = wr_sel_q;
    hi_d     = hi_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
`ifdef ALU_EXEC_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          dst_d   = dst;
          a_d     = opa;
          b_d     = opb;
          state_d = S_EXEC;
`ifdef ALU_EXEC_MUL_EN
          cnt_d   = '0;
          acc_d   = {{W{1'b0}}, opb};
`endif
        end
      end
      S_EXEC: begin
`ifdef ALU_EXEC_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_WB;
            wr_sel_d = dst_q;
            result_d = mul_next[W-1:0];
            hi_d     = mul_next[2*W-1:W];
            z_d      = (mul_next[W-1:0] == '0);
            c_d      = |mul_next[2*W-1:W];
            v_d      = 1'b0;
          end
        end else
`endif
        begin
          state_d  = S_WB;
          wr_sel_d = dst_q;
          result_d = alu_r;
          hi_d     = '0;
          z_d      = (alu_r == '0);
          c_d      = alu_c;
          v_d      = alu_v;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      wr_sel_q <= '0;
      hi_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      wr_sel_q <= wr_sel_d;
      hi_q     <= hi_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
`ifdef ALU_EXEC_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_WB);
  assign wr_en  = done;
  assign result = result_q;
  assign wr_sel = wr_sel_q;
  assign hi     = hi_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table for each op plus handshake and reset corner sequences.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op, dst;
  logic [7:0] opa, opb;
  logic       busy, done, wr_en, flag_z, flag_c, flag_v;
  logic [7:0] result, hi;
  logic [2:0] wr_sel;

  int checks = 0;
  int passed = 0;

`ifdef ALU_EXEC_MUL_EN
  localparam int MUL_LAT = 8;
  localparam logic [7:0] SPAM_R = 8'h04;
`else
  localparam int MUL_LAT = 1;
  localparam logic [7:0] SPAM_R = 8'h14;
`endif

  always #5 clk = ~clk;

  alu_exec #(.W(8), .MUL_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .wr_en(wr_en), .wr_sel(wr_sel), .hi(hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Launch one op and return the number of edges after the accepting edge until wr_en is seen.
  task automatic run_op(input logic [2:0] o, input logic [2:0] d, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; dst = d; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!wr_en && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] dst;
    logic [7:0] a, b, r, h;
    logic       z, c, v;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [2:0] o, input logic [2:0] d, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] r, input logic [7:0] h,
                              input logic z, input logic c, input logic v, input int lat);
    vec_t t;
    t.op = o; t.dst = d; t.a = a; t.b = b; t.r = r; t.h = h;
    t.z = z; t.c = c; t.v = v; t.lat = lat;
    return t;
  endfunction

  initial begin
    int lat;
    int writes;
    vecs[0]  = mk(3'b000, 3'd3, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    vecs[1]  = mk(3'b001, 3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    vecs[2]  = mk(3'b001, 3'd2, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    vecs[3]  = mk(3'b010, 3'd4, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    vecs[4]  = mk(3'b011, 3'd5, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    vecs[5]  = mk(3'b100, 3'd6, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    vecs[6]  = mk(3'b101, 3'd7, 8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    vecs[7]  = mk(3'b110, 3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    vecs[8]  = mk(3'b000, 3'd2, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    vecs[9]  = mk(3'b001, 3'd3, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_EXEC_MUL_EN
    vecs[10] = mk(3'b111, 3'd4, 8'd20, 8'd13, 8'h04, 8'h01, 1'b0, 1'b1, 1'b0, 8);
    vecs[11] = mk(3'b111, 3'd5, 8'd15, 8'd17, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8);
`else
    vecs[10] = mk(3'b111, 3'd4, 8'h5A, 8'h33, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    vecs[11] = mk(3'b111, 3'd5, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
`endif

    rst = 1'b1; start = 1'b0; op = '0; dst = '0; opa = '0; opb = '0;
    #12;
    chk("reset_ctl", {busy, done, wr_en}, 0);
    chk("reset_data", {result, hi, wr_sel, flag_z, flag_c, flag_v}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_done", i), {done, busy}, 2'b11);
      chk($sformatf("v%0d_result", i), result, vecs[i].r);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].h);
      chk($sformatf("v%0d_wr_sel", i), wr_sel, vecs[i].dst);
      chk($sformatf("v%0d_flags_zcv", i), {flag_z, flag_c, flag_v}, {vecs[i].z, vecs[i].c, vecs[i].v});
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_drop", i), {wr_en, busy}, 0);
      chk($sformatf("v%0d_hold", i), {result, wr_sel}, {vecs[i].r, vecs[i].dst});
    end

    // start held high through a multiply while operands change underneath it
    @(negedge clk);
    start = 1'b1; op = 3'b111; opa = 8'h14; opb = 8'h0D; dst = 3'd5;
    @(posedge clk); #1;
    op = 3'b000; opa = 8'h33; opb = 8'h11; dst = 3'd6;
    lat = 0;
    while (!wr_en && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("spam_latency", lat, MUL_LAT);
    chk("spam_result", result, SPAM_R);
    chk("spam_wr_sel", wr_sel, 5);
    @(posedge clk); #1;
    chk("spam_wb_start_ignored", {busy, wr_en}, 0);
    @(posedge clk); #1;
    chk("spam_next_accept", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!wr_en && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("spam2_latency", lat, 1);
    chk("spam2_result", result, 8'h44);
    chk("spam2_wr_sel", wr_sel, 6);
    @(posedge clk); #1;

    // reset while the multiply (or pass-through) is still executing
    @(negedge clk);
    start = 1'b1; op = 3'b111; opa = 8'h14; opb = 8'h0D; dst = 3'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {busy, done, wr_en}, 0);
    chk("rst_mid_data", {result, hi, wr_sel, flag_z, flag_c, flag_v}, 0);
    @(negedge clk); rst = 1'b0;
    writes = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (wr_en) writes++;
    end
    chk("rst_no_write", writes, 0);
    run_op(3'b000, 3'd1, 8'h01, 8'h01, lat);
    chk("post_rst_latency", lat, 1);
    chk("post_rst_result", result, 8'h02);
    chk("post_rst_wr_sel", wr_sel, 1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
